// File: rtl/add_multiply_pkg.sv
// Shared widths and operand/result types for the add_multiply scheduler slice.
package add_multiply_pkg;

  localparam int W_IN  = 15;
  localparam int W_OUT = 31;

  typedef logic signed [W_IN-1:0]  operand_t;
  typedef logic signed [W_OUT-1:0] result_t;

endpackage

// File: rtl/add_multiply_sched_if.sv
// Requester, datapath and result signals of add_multiply_sched bundled as one interface.
interface add_multiply_sched_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  import add_multiply_pkg::*;

  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W_IN-1:0] req_a;
  logic [N*W_IN-1:0] req_b;
  logic [N*W_IN-1:0] req_c;
  operand_t          op_a;
  operand_t          op_b;
  operand_t          op_c;
  logic              op_ce;
  result_t           op_y;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  result_t           res_y;

  modport master (
    output req_valid, req_a, req_b, req_c, op_y, res_ready,
    input  req_ready, op_a, op_b, op_c, op_ce, res_valid, res_id, res_y
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, op_y, res_ready,
    output req_ready, op_a, op_b, op_c, op_ce, res_valid, res_id, res_y
  );

endinterface

// File: rtl/rr_arbiter.sv
// Requester arbiter: rotating round-robin when ADD_MULT_SCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;

`ifdef ADD_MULT_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  // Next search start: one past the requester that was just accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  logic unused_s;

  assign ptr_s    = '0;
  assign unused_s = ^{clk, rst, advance};
`endif

  // First asserted request at or after ptr, wrapping modulo N.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int off = 0; off < N; off++) begin
      idx_s = IDW'((int'(ptr_s) + off) % N);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_id     = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/add_multiply_sched.sv
// Scheduler sharing one pipelined (A+B)*C datapath between N requesters.
// Arbitration mode selected by ADD_MULT_SCHED_RR_EN (see rr_arbiter).
module add_multiply_sched
  import add_multiply_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 3,
  parameter int IDW = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  add_multiply_sched_if.slave bus
);

  logic [N-1:0]            grant_s;
  logic [IDW-1:0]          grant_id_s;
  logic                    op_ce_s;
  logic                    accept_s;
  operand_t                op_a_s;
  operand_t                op_b_s;
  operand_t                op_c_s;
  logic [LAT-1:0]          vld_q;
  logic [LAT-1:0]          vld_d;
  logic [LAT-1:0][IDW-1:0] id_q;
  logic [LAT-1:0][IDW-1:0] id_d;

  // A pending result that is not being taken freezes the datapath and the tracker together.
  assign op_ce_s  = !vld_q[LAT-1] || bus.res_ready;
  assign accept_s = |(bus.req_valid & grant_s) && op_ce_s;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (!rst),
    .advance  (accept_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Operand mux from the granted requester, zero when nobody is granted.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    op_c_s = '0;
    if (|grant_s) begin
      op_a_s = operand_t'(bus.req_a[int'(grant_id_s) * W_IN +: W_IN]);
      op_b_s = operand_t'(bus.req_b[int'(grant_id_s) * W_IN +: W_IN]);
      op_c_s = operand_t'(bus.req_c[int'(grant_id_s) * W_IN +: W_IN]);
    end else begin
      op_a_s = '0;
      op_b_s = '0;
      op_c_s = '0;
    end
  end

  // In-flight tracker: shifts in lockstep with the datapath clock enable.
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    if (op_ce_s) begin
      vld_d[0] = accept_s;
      id_d[0]  = grant_id_s;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      id_d  = id_q;
    end
  end

  // Tracker registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign bus.req_ready = grant_s & {N{op_ce_s}};
  assign bus.op_a      = op_a_s;
  assign bus.op_b      = op_b_s;
  assign bus.op_c      = op_c_s;
  assign bus.op_ce     = op_ce_s;
  assign bus.res_valid = vld_q[LAT-1];
  assign bus.res_id    = id_q[LAT-1];
  assign bus.res_y     = bus.op_y;

endmodule

// File: doc/add_multiply_sched.md
# add_multiply_sched

Round-robin scheduler sharing one pipelined `add_multiply` datapath (Y = (A+B)*C, 15-bit signed operands, 31-bit signed result) between N requesters. It arbitrates operand requests, drives the datapath operands and `ce`, tracks in-flight operations with an ID shift register matched to the datapath latency, and returns each result tagged with its requester ID. Backpressure on the result port stalls the whole pipeline through `ce`.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `LAT`, 3: `add_multiply` latency in `ce`-enabled cycles, operand launch to valid `Y`.
- `IDW`, `$clog2(N)`: requester ID width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N: per-requester operand valid.
- `req_ready` out N: per-requester accept; at most one bit high.
- `req_a`, `req_b`, `req_c` in N*15 each: flattened signed operands; requester i occupies bits [15i+14:15i].
- `op_a`, `op_b`, `op_c` out 15 each: operands to `add_multiply`.
- `op_ce` out 1: clock enable to `add_multiply`.
- `op_y` in 31: `add_multiply` result.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer accept.
- `res_id` out IDW: requester ID of the current result.
- `res_y` out 31: signed result, equal to `op_y`.

## Operation
- Stall rule: `op_ce = !res_valid || res_ready`. When `op_ce` is low, nothing advances and no request is accepted.
- Arbitration (RR build): among the asserted `req_valid`, grant the first index at or after `ptr`, searching upward and wrapping modulo N.
  - `req_ready[g] = grant[g] && op_ce`.
  - `op_a/b/c` are muxed combinationally from the granted requester; with no grant they are driven to 0.
- Accept: `req_valid[g] && req_ready[g]`. On accept, `ptr <= (g+1) mod N`; otherwise `ptr` holds.
- Tracker: `vld[0..LAT-1]` and `id[0..LAT-1]`. When `op_ce` is high, stage 0 loads (accept, g) and the other stages shift. When `op_ce` is low, all stages hold.
- Result port: `res_valid = vld[LAT-1]`, `res_id = id[LAT-1]`, `res_y = op_y`.
  - A result held under stall stays stable because `add_multiply` is also held by `op_ce`.
- Arithmetic: A+B is sign-extended to 16 bits and multiplied by C, giving a full 31-bit product with no overflow. The scheduler does not alter values.
- Idle cycles with `op_ce` high insert bubbles (`vld` = 0).
- Throughput: one operation per cycle while `res_ready` is high.

## Timing
- Reset values: `vld` all 0, `id` all 0, `ptr` = 0. Outputs: `res_valid` 0, `res_id` 0, `req_ready` 0 while `rst` is asserted, `op_ce` 1, `op_a/b/c` 0.
- Latency: a request accepted at edge k yields `res_valid` at edge k+LAT, if there are no stalls. Each stall cycle adds one.
- `res_valid && !res_ready`: the result, ID and all in-flight stages hold, and `req_ready` is all 0.
- Output handshake and new request in the same cycle (`res_valid && res_ready` plus a request): both proceed.
- Reset mid-operation: all in-flight operations are discarded and no result is emitted for them. Datapath contents are don't-care because `vld` is cleared.
- A `req_valid` deasserted before its accept is legal; the grant re-evaluates each cycle.

## Configuration
- `ADD_MULT_SCHED_RR_EN` defined: round-robin with rotating `ptr` as above.
- Not defined: fixed priority, lowest index wins. `ptr` is not implemented (constant 0).

## Structure
- Package `add_multiply_pkg`:
  - `W_IN = 15`, `W_OUT = 31`.
  - Typedefs `operand_t` (signed [14:0]) and `result_t` (signed [30:0]).
- Sub-module `rr_arbiter` (N, IDW): inputs `req`, `en`, `advance`; outputs one-hot `grant`, `grant_id`. It owns `ptr` and the macro selection.
- The top level holds the operand mux, the tracker shift register and the `op_ce` logic.

## Test plan
All scenarios use N=4 and LAT=3, with the real `add_multiply` attached.
- Single request, req 2: A=5, B=-3, C=7 accepted at edge 1 -> `res_valid` at edge 4, `res_y`=14, `res_id`=2, for one cycle.
- All four requesting continuously, `res_ready`=1 (RR build) -> grants 0,1,2,3,0… one per cycle; results arrive in the same ID order at 1/cycle.
- Same stimulus in the fixed-priority build -> req 0 is granted every cycle; the others starve until req 0 drops.
- `res_ready` low for 5 cycles while 3 operations are in flight -> `op_ce`=0, `req_ready`=0, and `res_y`/`res_id` are stable. After release the three results emit on consecutive cycles with none lost or duplicated.
- Boundary values: A=-16384, B=-16384, C=-16384 -> `res_y` = +536870912. A=16383, B=16383, C=-16384 -> `res_y` = -536838144.
- `rst` pulsed with 2 operations in flight -> no `res_valid` afterward. `ptr` = 0, and the next request from req 0 completes normally after 3 cycles.
